n_minmax_tracker: RTL and testbench
===================================

Name: n_minmax_tracker

Overview:
- Streaming unsigned min/max tracker that sits directly downstream of the n-bit magnitude comparator stage.
- Accepts a frame of FRAME_LEN samples over a valid/ready handshake.
- Compares each sample against the running maximum and minimum using greater-than and less-than decisions.
- At frame end, presents the extreme values and their sample indices with a one-cycle done pulse.

Parameters:
- N, 8, sample width in bits; all comparisons unsigned.
- FRAME_LEN, 16, samples per frame; legal range 2 to 2**IDX_W.
- IDX_W, 4, width of the sample index and counter; must hold FRAME_LEN-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begins a frame; honoured only in IDLE.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  N  sample, unsigned.
- in_ready  output  1  block accepts a sample this cycle.
- busy  output  1  high in COLLECT and DONE.
- done  output  1  one-cycle pulse when results are final.
- max_val  output  N  largest sample of the last frame.
- min_val  output  N  smallest sample of the last frame.
- max_idx  output  IDX_W  index (0-based) of the first occurrence of max_val.
- min_idx  output  IDX_W  index of the first occurrence of min_val.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; counter is 0.
  - in_ready, busy, done, max_val, min_val, max_idx and min_idx are all 0.
  - Release is synchronous to clk; the first active edge after release sees IDLE.
- States: IDLE, COLLECT, DONE; all outputs are registered or decoded from state.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 at an edge moves to COLLECT and clears the counter to 0.
  - Result registers hold the previous frame's values.
- COLLECT:
  - in_ready=1, busy=1.
  - A sample is accepted when in_valid=1 at an edge; no acceptance when in_valid=0, and the counter holds.
- Per accepted sample (counter value k):
  - k=0: max_val=min_val=in_data; max_idx=min_idx=0.
  - k>0, in_data>max_val: max_val=in_data, max_idx=k.
  - k>0, in_data<min_val: min_val=in_data, min_idx=k.
  - Equal values do not update, so the first occurrence wins ties.
  - Both max and min can update in the same cycle only at k=0.
  - The counter increments after every accepted sample.
- Leaving COLLECT: when the sample with k=FRAME_LEN-1 is accepted, go to DONE on that edge and set the counter to 0.
- DONE:
  - Lasts exactly one cycle: done=1, in_ready=0, busy=1, then IDLE.
  - Results are final from the first cycle of DONE.
  - Results remain stable until the first sample of the next frame is accepted.
- start outside IDLE is ignored (no restart, no counter change).
- start held high continuously gives back-to-back frames: DONE, then IDLE for one cycle, then COLLECT.
- in_data is sampled only on acceptance; values on non-accepted cycles have no effect.
- Reset mid-frame discards the partial frame; all outputs return to their reset values.
- Latency: done asserts on the cycle after the edge that accepts the last sample. A frame with no stall cycles takes FRAME_LEN+1 cycles from the first acceptance to done.
- Extremes: 0 and 2**N-1 are handled as ordinary unsigned values; no signed interpretation, no overflow.

Test Plan:
1. Defaults, start, then 16 consecutive samples 5,9,3,200,7,0,255,12,255,1,0,8,8,4,6,2 -> done on the 17th cycle after the first acceptance; max_val=255, max_idx=6; min_val=0, min_idx=5.
2. All 16 samples =123 -> max_val=min_val=123; max_idx=min_idx=0; done pulses exactly one cycle.
3. Same data as scenario 1 with in_valid low for 3 cycles after sample 4 and 1 cycle after sample 10 -> identical results; done arrives 4 cycles later; counter holds during gaps.
4. Pulse start mid-COLLECT after sample 7 -> ignored; frame completes after 16 acceptances with correct results.
5. Assert rst asynchronously (off clock edge) after sample 9 -> all outputs 0 immediately. A new start plus 16 samples of descending 15..0 -> max_val=15, max_idx=0, min_val=0, min_idx=15.
6. start held high across two frames (first all 10, second 20,30,…) -> second frame results are independent of the first. Previous results stay visible during IDLE and are overwritten at the first acceptance of the new frame.

Source files
------------

// File: rtl/n_minmax_tracker.sv
// Streaming unsigned min/max tracker: collects FRAME_LEN samples over valid/ready,
// then reports the first-occurrence extremes and their indices with a done pulse.
module n_minmax_tracker #(
  parameter int N         = 8,
  parameter int FRAME_LEN = 16,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     max_val,
  output logic [N-1:0]     min_val,
  output logic [IDX_W-1:0] max_idx,
  output logic [IDX_W-1:0] min_idx
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  state_t           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             in_ready_q, busy_q, done_q;
  logic [N-1:0]     max_q, min_q, max_d, min_d;
  logic [IDX_W-1:0] max_idx_q, min_idx_q, max_idx_d, min_idx_d;

  // Strict compares keep the first occurrence on ties; k=0 seeds both extremes.
  always_comb begin
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    if (cnt_q == '0) begin
      max_d     = in_data;
      min_d     = in_data;
      max_idx_d = '0;
      min_idx_d = '0;
    end else begin
      if (in_data > max_q) begin
        max_d     = in_data;
        max_idx_d = cnt_q;
      end
      if (in_data < min_q) begin
        min_d     = in_data;
        min_idx_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      max_q      <= '0;
      min_q      <= '0;
      max_idx_q  <= '0;
      min_idx_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_COLLECT;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (in_valid) begin
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            if (cnt_q == LAST) begin
              state_q    <= S_DONE;
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign max_val  = max_q;
  assign min_val  = min_q;
  assign max_idx  = max_idx_q;
  assign min_idx  = min_idx_q;

endmodule

// File: tb/tb_n_minmax_tracker.sv
// Directed bench for n_minmax_tracker: a queue-based frame model checked every
// cycle, plus literal expectations for each scenario's final results.
module tb_n_minmax_tracker;
  localparam int N  = 8;
  localparam int FL = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start, in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready, busy, done;
  logic [N-1:0]  max_val, min_val;
  logic [IW-1:0] max_idx, min_idx;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] s1 [16] = '{8'd5, 8'd9, 8'd3, 8'd200, 8'd7, 8'd0, 8'd255, 8'd12,
                          8'd255, 8'd1, 8'd0, 8'd8, 8'd8, 8'd4, 8'd6, 8'd2};

  n_minmax_tracker #(.N(N), .FRAME_LEN(FL), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done),
    .max_val(max_val), .min_val(min_val), .max_idx(max_idx), .min_idx(min_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=collect 2=done; results are a scan of this frame's accepted samples.
  int q[$];
  int m_mode = 0;
  int m_max = 0, m_min = 0, m_maxi = 0, m_mini = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      q.delete();
      m_max = 0; m_min = 0; m_maxi = 0; m_mini = 0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; q.delete(); end
        1: if (in_valid) begin
             q.push_back(int'(in_data));
             m_max = q[0]; m_maxi = 0; m_min = q[0]; m_mini = 0;
             for (int i = 1; i < q.size(); i++) begin
               if (q[i] > m_max) begin m_max = q[i]; m_maxi = i; end
               if (q[i] < m_min) begin m_min = q[i]; m_mini = i; end
             end
             if (q.size() == FL) m_mode = 2;
           end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(m_mode == 1));
    check("busy",     32'(busy),     32'(m_mode != 0));
    check("done",     32'(done),     32'(m_mode == 2));
    check("max_val",  32'(max_val),  m_max);
    check("min_val",  32'(min_val),  m_min);
    check("max_idx",  32'(max_idx),  m_maxi);
    check("min_idx",  32'(min_idx),  m_mini);
  end

  task automatic begin_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd250;
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    in_data  = 8'd250;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(output int c);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check("done_seen", 32'(done), 32'd1);
    c = cyc;
  endtask

  task automatic expect_res(input string tag, input int mx, input int mxi, input int mn, input int mni);
    check({tag, "_max"},  32'(max_val), mx);
    check({tag, "_maxi"}, 32'(max_idx), mxi);
    check({tag, "_min"},  32'(min_val), mn);
    check({tag, "_mini"}, 32'(min_idx), mni);
  endtask

  initial begin
    int t0, c;
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    expect_res("reset", 0, 0, 0, 0);
    check("reset_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: mixed data, no stalls
    begin_frame();
    for (int i = 0; i < FL; i++) begin
      send(s1[i]);
      if (i == 0) t0 = cyc;
    end
    wait_done(c);
    check("s1_latency", c - t0, 15);
    expect_res("s1", 255, 6, 0, 5);
    @(negedge clk);
    check("s1_done_pulse", 32'(done), 0);

    // 2: constant data
    begin_frame();
    for (int i = 0; i < FL; i++) send(8'd123);
    wait_done(c);
    expect_res("s2", 123, 0, 123, 0);
    @(negedge clk);
    check("s2_done_pulse", 32'(done), 0);
    check("s2_idle_busy", 32'(busy), 0);

    // 3: stalls after samples 4 and 10
    begin_frame();
    for (int i = 0; i < FL; i++) begin
      send(s1[i]);
      if (i == 0) t0 = cyc;
      if (i == 4) gap(3);
      if (i == 10) gap(1);
    end
    wait_done(c);
    check("s3_latency", c - t0, 19);
    expect_res("s3", 255, 6, 0, 5);
    @(negedge clk);

    // 4: start pulsed mid-frame is ignored
    begin_frame();
    for (int i = 0; i < FL; i++) begin
      send(s1[i]);
      if (i == 0) t0 = cyc;
      if (i == 7) begin start = 1'b1; gap(1); start = 1'b0; end
    end
    wait_done(c);
    check("s4_latency", c - t0, 16);
    expect_res("s4", 255, 6, 0, 5);
    @(negedge clk);

    // 5: async reset mid-frame, then descending frame
    begin_frame();
    for (int i = 0; i < 10; i++) send(s1[i]);
    #2 rst = 1'b1;
    #1;
    expect_res("s5_rst", 0, 0, 0, 0);
    check("s5_rst_busy", 32'(busy), 0);
    check("s5_rst_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    begin_frame();
    for (int i = 0; i < FL; i++) send(8'(15 - i));
    wait_done(c);
    expect_res("s5", 15, 0, 0, 15);
    @(negedge clk);

    // 6: start held high, back-to-back frames
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < FL; i++) send(8'd10);
    wait_done(c);
    expect_res("s6a", 10, 0, 10, 0);
    in_valid = 1'b1; in_data = 8'd99;
    @(negedge clk);
    check("s6_idle_busy", 32'(busy), 0);
    expect_res("s6_hold", 10, 0, 10, 0);
    @(negedge clk);
    check("s6_collect_ready", 32'(in_ready), 1);
    send(8'd20);
    expect_res("s6_first", 20, 0, 20, 0);
    for (int i = 1; i < FL; i++) send(8'(20 + 10 * i));
    start = 1'b0;
    wait_done(c);
    expect_res("s6b", 170, 15, 20, 0);
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
